usb_speed_detect: RTL and testbench

Parametrised successor of the front-end USB speed autodetector; sits in the `fe_clk` domain between the PHY linestate pins and the register block. Adds the following over the previous detector:
- linestate synchronisation and debounce;
- run-time programmable timing thresholds;
- LS/FS disconnect detection that automatically re-arms detection;
- a saturating error counter and a one-cycle done strobe.

Reports LS/FS/HS using the `USB_SPEED_*` encodings from `defines.v`.

---
 rtl/usb_speed_detect_pkg.sv | 25 ++
 rtl/linestate_debounce.sv | 56 +++++
 rtl/usb_speed_detect.sv | 150 +++++++++++++++
 tb/tb_usb_speed_detect.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_speed_detect_pkg.sv
// Shared constants for the USB speed autodetector: speed encodings, linestate
// codes and the fixed FSM state encoding also exposed on O_state.
package usb_speed_detect_pkg;

    localparam logic [1:0] USB_SPEED_AUTO = 2'b00;
    localparam logic [1:0] USB_SPEED_LS   = 2'b01;
    localparam logic [1:0] USB_SPEED_FS   = 2'b10;
    localparam logic [1:0] USB_SPEED_HS   = 2'b11;

    localparam logic [1:0] LS_SE0  = 2'b00;
    localparam logic [1:0] LS_J_FS = 2'b01;
    localparam logic [1:0] LS_K_FS = 2'b10;
    localparam logic [1:0] LS_SE1  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LS_J     = 3'd1,
        ST_FS_J     = 3'd2,
        ST_WAIT_SE0 = 3'd3,
        ST_HS_SE0   = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERROR    = 3'd6
    } state_t;

endpackage

// File: rtl/linestate_debounce.sv
// Two-flop synchroniser for the raw PHY linestate followed by a stability
// filter: o_ls_f moves only after pDEBOUNCE consecutive equal samples.
module linestate_debounce
    import usb_speed_detect_pkg::*;
#(
    parameter int pDEBOUNCE = 4
) (
    input  logic       fe_clk,
    input  logic       reset_n,
    input  logic [1:0] i_linestate,
    output logic [1:0] o_ls_f
);

    localparam logic [7:0] DEB_LEN = 8'(pDEBOUNCE);

    logic [1:0] r_sync0;
    logic [1:0] r_sync1;
    logic [1:0] r_cand;
    logic [1:0] r_ls_f;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;

    // Run length of identical synchronised samples, saturating at DEB_LEN.
    always_comb begin
        if (r_sync1 != r_cand) begin
            w_cnt_next = 8'd1;
        end else if (r_cnt == DEB_LEN) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    // NOTE: the run counter resets already saturated so the reset value of
    // r_cand counts as long-stable and cannot trigger a spurious commit.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync0 <= LS_SE0;
            r_sync1 <= LS_SE0;
            r_cand  <= LS_SE0;
            r_cnt   <= DEB_LEN;
            r_ls_f  <= LS_SE0;
        end else begin
            r_sync0 <= i_linestate;
            r_sync1 <= r_sync0;
            r_cand  <= r_sync1;
            r_cnt   <= w_cnt_next;
            if (w_cnt_next == DEB_LEN) begin
                r_ls_f <= r_sync1;
            end
        end
    end

    assign o_ls_f = r_ls_f;

endmodule

// File: rtl/usb_speed_detect.sv
// USB LS/FS/HS speed autodetector with programmable phase thresholds,
// LS/FS disconnect re-arm, saturating error count and a done strobe.
module usb_speed_detect
    import usb_speed_detect_pkg::*;
#(
    parameter int pCOUNTER_WIDTH = 21,
    parameter int pDEBOUNCE      = 4,
    parameter int pERR_WIDTH     = 8
) (
    input  logic                      fe_clk,
    input  logic                      reset_n,
    input  logic [1:0]                fe_linestate,
    input  logic                      I_enable,
    input  logic                      I_restart,
    input  logic [pCOUNTER_WIDTH-1:0] I_wait_j,
    input  logic [pCOUNTER_WIDTH-1:0] I_wait_se0,
    input  logic [pCOUNTER_WIDTH-1:0] I_wait_disc,
    output logic [1:0]                O_speed,
    output logic                      O_done,
    output logic                      O_disconnect,
    output logic [pERR_WIDTH-1:0]     O_err_count,
    output logic [2:0]                O_state
);

    localparam logic [pCOUNTER_WIDTH-1:0] TIMER_ONE = pCOUNTER_WIDTH'(1);
    localparam logic [pERR_WIDTH-1:0]     ERR_ONE   = pERR_WIDTH'(1);

    logic [1:0]                w_ls_f;
    state_t                    r_state;
    state_t                    w_next;
    logic [pCOUNTER_WIDTH-1:0] r_timer;
    logic [pCOUNTER_WIDTH-1:0] w_timer_next;
    logic [pCOUNTER_WIDTH-1:0] w_timer_inc;
    logic [1:0]                r_speed;
    logic [1:0]                w_det_speed;
    logic                      r_done;
    logic                      r_disc;
    logic                      w_disc;
    logic [pERR_WIDTH-1:0]     r_err;

    linestate_debounce #(
        .pDEBOUNCE (pDEBOUNCE)
    ) u_debounce (
        .fe_clk      (fe_clk),
        .reset_n     (reset_n),
        .i_linestate (fe_linestate),
        .o_ls_f      (w_ls_f)
    );

    assign w_timer_inc = (&r_timer) ? r_timer : r_timer + TIMER_ONE;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_next      = r_state;
        w_det_speed = USB_SPEED_AUTO;
        w_disc      = 1'b0;
        if (!I_enable || I_restart) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ls_f == LS_K_FS)      w_next = ST_LS_J;
                    else if (w_ls_f == LS_J_FS) w_next = ST_FS_J;
                end
                ST_LS_J: begin
                    if (w_ls_f != LS_K_FS) begin
                        w_next = ST_ERROR;
                    end else if (r_timer == I_wait_j) begin
                        w_next      = ST_DONE;
                        w_det_speed = USB_SPEED_LS;
                    end
                end
                ST_FS_J: begin
                    if (w_ls_f != LS_J_FS)        w_next = ST_ERROR;
                    else if (r_timer == I_wait_j) w_next = ST_WAIT_SE0;
                end
                ST_WAIT_SE0: begin
                    if (w_ls_f == LS_SE0)       w_next = ST_HS_SE0;
                    else if (w_ls_f != LS_J_FS) w_next = ST_ERROR;
                end
                ST_HS_SE0: begin
                    if (r_timer == I_wait_se0) begin
                        w_next      = ST_DONE;
                        w_det_speed = USB_SPEED_HS;
                    end else if (w_ls_f == LS_J_FS) begin
                        w_next      = ST_DONE;
                        w_det_speed = USB_SPEED_FS;
                    end else if (w_ls_f != LS_SE0) begin
                        w_next = ST_ERROR;
                    end
                end
                ST_DONE: begin
                    // HS devices are never torn down by SE0; only LS/FS re-arm.
                    if ((r_speed != USB_SPEED_HS) && (w_ls_f == LS_SE0) &&
                        (r_timer == I_wait_disc)) begin
                        w_next = ST_IDLE;
                        w_disc = 1'b1;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // In DONE the timer measures the current unbroken SE0 run.
    always_comb begin
        w_timer_next = '0;
        if (w_next == r_state) begin
            case (r_state)
                ST_LS_J, ST_FS_J, ST_HS_SE0: w_timer_next = w_timer_inc;
                ST_DONE: w_timer_next = (w_ls_f == LS_SE0) ? w_timer_inc : '0;
                default: w_timer_next = '0;
            endcase
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_speed <= USB_SPEED_AUTO;
            r_done  <= 1'b0;
            r_disc  <= 1'b0;
            r_err   <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_next;
            r_done  <= (w_next == ST_DONE) && (r_state != ST_DONE);
            r_disc  <= w_disc;
            if (w_next != r_state) begin
                if (w_next == ST_DONE) begin
                    r_speed <= w_det_speed;
                end else if ((w_next == ST_IDLE) || (w_next == ST_ERROR)) begin
                    r_speed <= USB_SPEED_AUTO;
                end
            end
            if ((w_next == ST_ERROR) && (r_state != ST_ERROR) && !(&r_err)) begin
                r_err <= r_err + ERR_ONE;
            end
        end
    end

    assign O_speed      = r_speed;
    assign O_done       = r_done;
    assign O_disconnect = r_disc;
    assign O_err_count  = r_err;
    assign O_state      = r_state;

endmodule

// File: tb/tb_usb_speed_detect.sv
// Self-checking bench for usb_speed_detect: directed scenarios plus random
// linestate traffic compared every cycle against a behavioural model.
module tb_usb_speed_detect;
    import usb_speed_detect_pkg::*;

    localparam int CW      = 21;
    localparam int DEB     = 4;
    localparam int EW      = 2;
    localparam int ERR_MAX = (1 << EW) - 1;
    localparam int VW      = 7 + EW;

    logic          fe_clk;
    logic          reset_n;
    logic [1:0]    fe_linestate;
    logic          I_enable;
    logic          I_restart;
    logic [CW-1:0] I_wait_j;
    logic [CW-1:0] I_wait_se0;
    logic [CW-1:0] I_wait_disc;
    logic [1:0]    O_speed;
    logic          O_done;
    logic          O_disconnect;
    logic [EW-1:0] O_err_count;
    logic [2:0]    O_state;

    int checks      = 0;
    int failures    = 0;
    int fail_prints = 0;

    // Behavioural model state
    state_t     m_phase;
    longint     m_elapsed;
    longint     m_se0_run;
    logic [1:0] m_speed;
    logic [1:0] m_ls_f;
    logic       m_done;
    logic       m_disc;
    int         m_err;
    logic [1:0] q_pins[$];

    usb_speed_detect #(
        .pCOUNTER_WIDTH (CW),
        .pDEBOUNCE      (DEB),
        .pERR_WIDTH     (EW)
    ) dut (
        .fe_clk       (fe_clk),
        .reset_n      (reset_n),
        .fe_linestate (fe_linestate),
        .I_enable     (I_enable),
        .I_restart    (I_restart),
        .I_wait_j     (I_wait_j),
        .I_wait_se0   (I_wait_se0),
        .I_wait_disc  (I_wait_disc),
        .O_speed      (O_speed),
        .O_done       (O_done),
        .O_disconnect (O_disconnect),
        .O_err_count  (O_err_count),
        .O_state      (O_state)
    );

    initial fe_clk = 1'b0;
    always #5 fe_clk = ~fe_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_phase   = ST_IDLE;
        m_elapsed = 0;
        m_se0_run = 0;
        m_speed   = USB_SPEED_AUTO;
        m_ls_f    = LS_SE0;
        m_done    = 1'b0;
        m_disc    = 1'b0;
        m_err     = 0;
        q_pins.delete();
        for (int i = 0; i < DEB + 2; i++) q_pins.push_back(2'b00);
    endtask

    // One clock edge of the reference: phases last threshold+1 cycles, a
    // disconnect needs wait_disc+1 SE0 cycles, filter needs DEB equal samples
    // that are two edges old.
    task automatic model_edge();
        state_t     nxt;
        logic [1:0] found;
        logic       disc;
        longint     cyc;
        bit         stable;
        nxt   = m_phase;
        found = USB_SPEED_AUTO;
        disc  = 1'b0;
        cyc   = m_elapsed + 1;
        if (!I_enable || I_restart) begin
            nxt = ST_IDLE;
        end else begin
            case (m_phase)
                ST_IDLE: begin
                    if (m_ls_f == LS_K_FS) nxt = ST_LS_J;
                    if (m_ls_f == LS_J_FS) nxt = ST_FS_J;
                end
                ST_LS_J: begin
                    if (m_ls_f != LS_K_FS) nxt = ST_ERROR;
                    else if (cyc == longint'(I_wait_j) + 1) begin
                        nxt = ST_DONE; found = USB_SPEED_LS;
                    end
                end
                ST_FS_J: begin
                    if (m_ls_f != LS_J_FS) nxt = ST_ERROR;
                    else if (cyc == longint'(I_wait_j) + 1) nxt = ST_WAIT_SE0;
                end
                ST_WAIT_SE0: begin
                    if (m_ls_f == LS_SE0) nxt = ST_HS_SE0;
                    else if (m_ls_f != LS_J_FS) nxt = ST_ERROR;
                end
                ST_HS_SE0: begin
                    if (cyc == longint'(I_wait_se0) + 1) begin
                        nxt = ST_DONE; found = USB_SPEED_HS;
                    end else if (m_ls_f == LS_J_FS) begin
                        nxt = ST_DONE; found = USB_SPEED_FS;
                    end else if (m_ls_f != LS_SE0) begin
                        nxt = ST_ERROR;
                    end
                end
                ST_DONE: begin
                    if (m_speed != USB_SPEED_HS && m_ls_f == LS_SE0 &&
                        m_se0_run + 1 == longint'(I_wait_disc) + 1) begin
                        nxt = ST_IDLE; disc = 1'b1;
                    end
                end
                default: nxt = ST_IDLE;
            endcase
        end

        m_done = (nxt == ST_DONE) && (m_phase != ST_DONE);
        m_disc = disc;
        if (nxt != m_phase) begin
            if (nxt == ST_DONE) m_speed = found;
            if (nxt == ST_IDLE || nxt == ST_ERROR) m_speed = USB_SPEED_AUTO;
            if (nxt == ST_ERROR && m_err < ERR_MAX) m_err++;
            m_elapsed = 0;
            m_se0_run = 0;
        end else begin
            m_elapsed++;
            if (m_phase == ST_DONE) m_se0_run = (m_ls_f == LS_SE0) ? m_se0_run + 1 : 0;
        end
        m_phase = nxt;

        q_pins.push_back(fe_linestate);
        if (q_pins.size() > DEB + 2) void'(q_pins.pop_front());
        stable = 1'b1;
        for (int i = 1; i < DEB; i++) if (q_pins[i] != q_pins[0]) stable = 1'b0;
        if (stable) m_ls_f = q_pins[0];
    endtask

    task automatic tick();
        logic [VW-1:0] exp_v;
        logic [VW-1:0] got_v;
        @(posedge fe_clk);
        model_edge();
        #1;
        exp_v = {m_speed, m_done, m_disc, EW'(m_err), m_phase};
        got_v = {O_speed, O_done, O_disconnect, O_err_count, O_state};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            if (fail_prints < 20) begin
                fail_prints++;
                $display("FAIL cycle_model t=%0t got speed=%0d done=%0b disc=%0b err=%0d state=%0d expected speed=%0d done=%0b disc=%0b err=%0d state=%0d",
                         $time, O_speed, O_done, O_disconnect, O_err_count, O_state,
                         m_speed, m_done, m_disc, m_err, m_phase);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        fe_linestate = 2'b00;
        I_enable     = 1'b1;
        I_restart    = 1'b0;
        @(negedge fe_clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        fe_linestate = 2'b00;
        I_enable     = 1'b1;
        I_restart    = 1'b0;
        I_wait_j     = CW'(100);
        I_wait_se0   = CW'(500);
        I_wait_disc  = CW'(20);
        #2;
        checks++;
        if ({O_speed, O_done, O_disconnect, O_err_count, O_state} !==
            {USB_SPEED_AUTO, 1'b0, 1'b0, {EW{1'b0}}, 3'd0}) begin
            failures++;
            $display("FAIL reset_values got speed=%0d done=%0b disc=%0b err=%0d state=%0d expected all zero",
                     O_speed, O_done, O_disconnect, O_err_count, O_state);
        end
        @(negedge fe_clk);
        @(negedge fe_clk);
        reset_n = 1'b1;
        model_reset();
        run(5);
    endtask

    task automatic test_ls_latency();
        int cyc;
        bit seen;
        do_reset();
        I_wait_j = CW'(100);
        run(3);
        fe_linestate = 2'b10;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            tick();
            cyc++;
            if (O_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc != 108) begin
            failures++;
            $display("FAIL ls_done_latency got %0d cycles (seen=%0b) expected 108", cyc, seen);
        end
        checks++;
        if (O_speed !== USB_SPEED_LS) begin
            failures++;
            $display("FAIL ls_speed got %0d expected %0d", O_speed, USB_SPEED_LS);
        end
        tick();
        checks++;
        if (O_done !== 1'b0) begin
            failures++;
            $display("FAIL ls_done_one_cycle got %0b expected 0", O_done);
        end
    endtask

    task automatic test_hs();
        int cyc;
        bit seen;
        do_reset();
        I_wait_j   = CW'(100);
        I_wait_se0 = CW'(500);
        fe_linestate = 2'b01;
        run(200);
        fe_linestate = 2'b00;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 700) begin
            tick();
            cyc++;
            if (O_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc != 508) begin
            failures++;
            $display("FAIL hs_done_latency got %0d cycles (seen=%0b) expected 508", cyc, seen);
        end
        checks++;
        if (O_speed !== USB_SPEED_HS) begin
            failures++;
            $display("FAIL hs_speed got %0d expected %0d", O_speed, USB_SPEED_HS);
        end
        run(10000);
        checks++;
        if (O_speed !== USB_SPEED_HS || O_state !== ST_DONE) begin
            failures++;
            $display("FAIL hs_no_disconnect got speed=%0d state=%0d expected speed=%0d state=%0d",
                     O_speed, O_state, USB_SPEED_HS, ST_DONE);
        end
    endtask

    task automatic test_fs_disconnect();
        int cyc;
        int discs;
        int disc_at;
        bit seen;
        do_reset();
        I_wait_j    = CW'(100);
        I_wait_se0  = CW'(500);
        I_wait_disc = CW'(20);
        fe_linestate = 2'b01;
        run(200);
        fe_linestate = 2'b00;
        run(50);
        fe_linestate = 2'b01;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            tick();
            cyc++;
            if (O_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || O_speed !== USB_SPEED_FS) begin
            failures++;
            $display("FAIL fs_speed got %0d (done seen=%0b) expected %0d", O_speed, seen, USB_SPEED_FS);
        end
        run(10);
        discs = 0;
        fe_linestate = 2'b00;
        repeat (20) begin tick(); if (O_disconnect === 1'b1) discs++; end
        fe_linestate = 2'b01;
        repeat (40) begin tick(); if (O_disconnect === 1'b1) discs++; end
        checks++;
        if (discs != 0 || O_state !== ST_DONE) begin
            failures++;
            $display("FAIL short_se0_no_disc got pulses=%0d state=%0d expected pulses=0 state=%0d",
                     discs, O_state, ST_DONE);
        end
        fe_linestate = 2'b00;
        disc_at = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (O_disconnect === 1'b1) begin
                discs++;
                disc_at = i;
                checks++;
                if (O_speed !== USB_SPEED_AUTO || O_state !== ST_IDLE) begin
                    failures++;
                    $display("FAIL disc_outputs got speed=%0d state=%0d expected speed=0 state=0",
                             O_speed, O_state);
                end
            end
        end
        checks++;
        if (discs != 1 || disc_at != 27) begin
            failures++;
            $display("FAIL disc_pulse got count=%0d at=%0d expected count=1 at=27", discs, disc_at);
        end
    endtask

    task automatic test_error();
        bit seen;
        do_reset();
        I_wait_j = CW'(100);
        fe_linestate = 2'b10;
        run(50);
        fe_linestate = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (O_state === ST_ERROR) seen = 1'b1;
        end
        checks++;
        if (!seen || O_err_count !== EW'(1) || O_speed !== USB_SPEED_AUTO) begin
            failures++;
            $display("FAIL error_entry got seen=%0b err=%0d speed=%0d expected seen=1 err=1 speed=0",
                     seen, O_err_count, O_speed);
        end
        tick();
        checks++;
        if (O_state !== ST_IDLE) begin
            failures++;
            $display("FAIL error_to_idle got state=%0d expected %0d", O_state, ST_IDLE);
        end
        run(20);
        checks++;
        if (O_state !== ST_FS_J) begin
            failures++;
            $display("FAIL fresh_fs_j got state=%0d expected %0d", O_state, ST_FS_J);
        end
        for (int k = 0; k < 4; k++) begin
            fe_linestate = (k % 2 == 0) ? 2'b10 : 2'b01;
            run(30);
        end
        checks++;
        if (O_err_count !== EW'(ERR_MAX)) begin
            failures++;
            $display("FAIL err_saturate got %0d expected %0d", O_err_count, ERR_MAX);
        end
    endtask

    task automatic test_restart_collision();
        bit hit;
        do_reset();
        I_wait_j = CW'(30);
        fe_linestate = 2'b10;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            if (m_phase == ST_LS_J && m_elapsed == 30) hit = 1'b1;
        end
        I_restart = 1'b1;
        tick();
        I_restart = 1'b0;
        checks++;
        if (!hit || O_done !== 1'b0 || O_state !== ST_IDLE || O_speed !== USB_SPEED_AUTO) begin
            failures++;
            $display("FAIL restart_vs_done got hit=%0b done=%0b state=%0d speed=%0d expected hit=1 done=0 state=0 speed=0",
                     hit, O_done, O_state, O_speed);
        end
        run(10);
    endtask

    task automatic test_async_reset();
        do_reset();
        I_wait_j   = CW'(100);
        I_wait_se0 = CW'(500);
        fe_linestate = 2'b10;
        run(20);
        fe_linestate = 2'b01;
        run(150);
        fe_linestate = 2'b00;
        run(60);
        checks++;
        if (O_state !== ST_HS_SE0 || O_err_count !== EW'(1)) begin
            failures++;
            $display("FAIL pre_reset_state got state=%0d err=%0d expected state=%0d err=1",
                     O_state, O_err_count, ST_HS_SE0);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({O_speed, O_done, O_disconnect, O_err_count, O_state} !==
            {USB_SPEED_AUTO, 1'b0, 1'b0, {EW{1'b0}}, 3'd0}) begin
            failures++;
            $display("FAIL async_reset got speed=%0d done=%0b disc=%0b err=%0d state=%0d expected all zero",
                     O_speed, O_done, O_disconnect, O_err_count, O_state);
        end
        @(negedge fe_clk);
        reset_n = 1'b1;
        model_reset();
        run(5);
    endtask

    task automatic test_random();
        int pick;
        int hold;
        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 3) == 0) begin
                I_wait_j    = CW'($urandom_range(3, 40));
                I_wait_se0  = CW'($urandom_range(10, 90));
                I_wait_disc = CW'($urandom_range(2, 25));
            end
            pick = $urandom_range(0, 99);
            if (pick < 35)      fe_linestate = 2'b00;
            else if (pick < 70) fe_linestate = 2'b01;
            else if (pick < 90) fe_linestate = 2'b10;
            else                fe_linestate = 2'b11;
            I_enable = ($urandom_range(0, 11) != 0);
            hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 120);
            for (int c = 0; c < hold; c++) begin
                I_restart = ($urandom_range(0, 199) == 0);
                tick();
            end
            I_restart = 1'b0;
        end
        I_enable = 1'b1;
        run(10);
    endtask

    initial begin
        test_reset();
        test_ls_latency();
        test_hs();
        test_fs_disconnect();
        test_error();
        test_restart_collision();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
